core_mul_sequencer: RTL and testbench
=====================================

# core_mul_sequencer

Two-requester arbiter and sequencer that time-shares one registered 16x16 unsigned multiplier cell to produce 32x32 products. It issues partial products over several cycles, accumulates them, and applies signed correction. It sits beside the Nios II A-stage. Requester 0 is the CPU multiply path; requester 1 is the custom-instruction/DSP accelerator port. Each accepted operation returns a single 32-bit result.

## Interface
- MUL_LATENCY, 1: register stages inside the internal 16x16 multiplier cell; legal values are 1..3.
- clk  in  1  sole clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src1, req0_src2  in  32  operands.
- req0_op  in  2  00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high word).
- req1_valid, req1_ready, req1_src1, req1_src2, req1_op: same meanings for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  32  product low word (MUL) or high word (MULX*).

## Operation
- States: IDLE, ISSUE, DRAIN, CORRECT, RESP.
- IDLE: grant logic
  - If only one valid is high, that requester is granted.
  - If both are high, the round-robin pointer decides.
  - reqN_ready = (state==IDLE) & granted N; this is combinational from valid and the pointer.
  - On handshake: latch src1 (a), src2 (b), op and id; clear the 64-bit accumulator; flip the pointer to the other requester; go to ISSUE.
- ISSUE: one partial product per cycle.
  - MUL issues 3 products: aL*bL (shift 0), aH*bL (shift 16), aL*bH (shift 16).
  - MULX* issues those 3 plus aH*bH (shift 32).
  - A shift tag travels alongside each product in a MUL_LATENCY-deep pipe.
  - Each product is added to the accumulator in the cycle it emerges from the cell.
  - After the last issue, go to DRAIN.
- DRAIN: lasts MUL_LATENCY cycles, until the pipe is empty. Then go to CORRECT.
- CORRECT: one cycle, signed correction on the high word (mod 2^32):
  - hi -= b if (op==01 or op==10) and a[31].
  - hi -= a if op==01 and b[31].
  - MUL and MULXUU pass through unchanged.
  - The result register gets acc[31:0] for MUL, otherwise the corrected hi. Go to RESP.
- RESP: rsp_valid=1. rsp_id and rsp_result are held stable until rsp_ready is seen. On the handshake, go to IDLE.
- No request is accepted outside IDLE. A request is never accepted in the same cycle as a response handshake.
- Requesters must hold valid and their operands stable until ready.
- Accumulator arithmetic is 64-bit unsigned with no overflow; partial-product wrap is impossible by construction.

## Timing
- Let the acceptance handshake occur in cycle 0 and N = number of products (3 or 4).
  - ISSUE occupies cycles 1..N.
  - DRAIN occupies cycles N+1..N+MUL_LATENCY.
  - CORRECT is cycle N+MUL_LATENCY+1.
  - rsp_valid first goes high in cycle N+MUL_LATENCY+2.
- With MUL_LATENCY=1: MUL responds in cycle 6, MULX* in cycle 7.
- Minimum spacing between acceptances: N+MUL_LATENCY+3 cycles (rsp_ready held high).
- Reset values:
  - State is IDLE and the pointer favours requester 0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, accumulator and product pipe cleared.
  - reqN_ready=0 during the reset cycle.
- Reset in any state aborts the operation in flight:
  - No response is ever produced for it.
  - Products still in the pipe are discarded and never accumulated.
- Simultaneous valids under continuous load are granted 0,1,0,1,...

## Configuration
- CORE_MUL_SEQ_SIGNED_EN defined: the CORRECT step applies signed correction for op 01/10 as above.
- Not defined: op 01 and 10 are computed exactly as MULXUU. The CORRECT state is still traversed, so latency and handshakes are identical and the correction subtractors are removed.

## Test plan
- req0 MUL, a=0x0001_0003, b=0x0002_0005, MUL_LATENCY=1 -> rsp_valid in cycle 6, rsp_result=0x000B_000F, rsp_id=0.
- req1 MULXUU, a=b=0xFFFF_FFFF -> rsp_valid in cycle 7, rsp_result=0xFFFF_FFFE, rsp_id=1.
- MULXSS a=b=0xFFFF_FFFF -> 0x0000_0000. MULXSU with the same operands -> 0xFFFF_FFFF.
  - Without CORE_MUL_SEQ_SIGNED_EN, both return 0xFFFF_FFFE.
- Both requesters valid continuously after reset -> grants alternate starting with requester 0, and rsp_id sequence is 0,1,0,1. Never more than one ready high.
- rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result are stable and both readys stay 0. The next acceptance happens the cycle after the response handshake.
- reset pulsed in cycle 2 of a MULXUU -> the next cycle has rsp_valid=0 and state IDLE, and no stale response appears. A following req0 MUL 7*6 returns 0x0000_002A.

Source files
------------

// File: rtl/core_mul_sequencer.sv
// Two-requester 32x32 multiply sequencer time-sharing one registered 16x16 multiplier cell.
// Build option: define CORE_MUL_SEQ_SIGNED_EN to enable signed correction for MULXSS/MULXSU.
module core_mul_sequencer #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCorrect, StResp} state_e;

  localparam logic [1:0] DrainLast = 2'(MUL_LATENCY - 1);

  state_e      state_q;
  logic        ptr_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic [1:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] pipe_prod_q [MUL_LATENCY];
  logic [1:0]  pipe_sh_q   [MUL_LATENCY];
  logic        pipe_vld_q  [MUL_LATENCY];
  logic        rsp_valid_q, rsp_id_q;
  logic [31:0] rsp_result_q;

  logic        gnt0, gnt1, in_idle;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_p;
  logic        last_issue;
  logic [63:0] addend;
  logic [31:0] hi;

  always_comb begin
    gnt0       = req0_valid & (~req1_valid | ~ptr_q);
    gnt1       = req1_valid & (~req0_valid | ptr_q);
    in_idle    = (state_q == StIdle) & ~reset;
    req0_ready = in_idle & gnt0;
    req1_ready = in_idle & gnt1;
    // Product order by cnt: aL*bL, aH*bL, aL*bH, aH*bH.
    mul_x      = cnt_q[0] ? a_q[31:16] : a_q[15:0];
    mul_y      = cnt_q[1] ? b_q[31:16] : b_q[15:0];
    mul_p      = {16'b0, mul_x} * {16'b0, mul_y};
    last_issue = (cnt_q == ((op_q == 2'b00) ? 2'd2 : 2'd3));
  end

  always_comb begin
    addend = 64'b0;
    case (pipe_sh_q[MUL_LATENCY-1])
      2'd0:    addend = {32'b0, pipe_prod_q[MUL_LATENCY-1]};
      2'd1:    addend = {16'b0, pipe_prod_q[MUL_LATENCY-1], 16'b0};
      2'd2:    addend = {pipe_prod_q[MUL_LATENCY-1], 32'b0};
      default: addend = 64'b0;
    endcase
  end

  always_comb begin
    hi = acc_q[63:32];
`ifdef CORE_MUL_SEQ_SIGNED_EN
    if ((op_q == 2'b01 || op_q == 2'b10) && a_q[31]) hi = hi - b_q;
    if (op_q == 2'b01 && b_q[31]) hi = hi - a_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        pipe_prod_q[i] <= '0;
        pipe_sh_q[i]   <= '0;
        pipe_vld_q[i]  <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= (state_q == StIssue);
      pipe_prod_q[0] <= mul_p;
      pipe_sh_q[0]   <= {cnt_q[0] & cnt_q[1], cnt_q[0] ^ cnt_q[1]};
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_prod_q[i] <= pipe_prod_q[i-1];
        pipe_sh_q[i]   <= pipe_sh_q[i-1];
      end
      if (pipe_vld_q[MUL_LATENCY-1]) acc_q <= acc_q + addend;

      unique case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            a_q     <= req1_ready ? req1_src1 : req0_src1;
            b_q     <= req1_ready ? req1_src2 : req0_src2;
            op_q    <= req1_ready ? req1_op : req0_op;
            id_q    <= req1_ready;
            ptr_q   <= req0_ready;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q <= cnt_q + 2'd1;
          if (last_issue) begin
            cnt_q   <= '0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == DrainLast) state_q <= StCorrect;
        end
        StCorrect: begin
          rsp_result_q <= (op_q == 2'b00) ? acc_q[31:0] : hi;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_core_mul_sequencer.sv
// Directed self-checking bench for core_mul_sequencer (MUL_LATENCY = 1).
module tb_core_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

`ifdef CORE_MUL_SEQ_SIGNED_EN
  localparam logic [31:0] ExpSs  = 32'h0000_0000;
  localparam logic [31:0] ExpSu  = 32'hFFFF_FFFF;
  localparam logic [31:0] ExpNeg = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] ExpSs  = 32'hFFFF_FFFE;
  localparam logic [31:0] ExpSu  = 32'hFFFF_FFFE;
  localparam logic [31:0] ExpNeg = 32'h0000_0002;
`endif

  core_mul_sequencer #(.MUL_LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_src1  (req0_src1),
    .req0_src2  (req0_src2),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_src1  (req1_src1),
    .req1_src2  (req1_src2),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  always #5 clk = ~clk;

  // Drives one operation from requester r; lat is the cycle (acceptance = 0) of first rsp_valid.
  task automatic run_op(input logic r, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] res,
                        output logic id);
    int w;
    lat = -1;
    res = '0;
    id = 1'b0;
    rsp_ready = 1'b1;
    if (r) begin
      req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
    end
    #1;
    w = 0;
    while (!(r ? req1_ready : req0_ready) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!(r ? req1_ready : req0_ready)) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      lat = -1;
      return;
    end
    res = rsp_result;
    id = rsp_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== 34'd0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b id=%b r=%h want all zero", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat;
    logic [31:0] res;
    logic id;
    run_op(1'b0, 2'b00, 32'h0001_0003, 32'h0002_0005, lat, res, id);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL mul_latency: got %0d want 6", lat);
    end
    checks++;
    if (res !== 32'h000B_000F) begin
      failures++;
      $display("FAIL mul_result: got %h want 000b000f", res);
    end
    checks++;
    if (id !== 1'b0) begin
      failures++;
      $display("FAIL mul_id: got %b want 0", id);
    end
    run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, id);
    checks++;
    if (res !== 32'h0000_0001) begin
      failures++;
      $display("FAIL mul_low_wrap: got %h want 00000001", res);
    end
  endtask

  task automatic test_mulxuu();
    int lat;
    logic [31:0] res;
    logic id;
    run_op(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, id);
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL mulxuu_latency: got %0d want 7", lat);
    end
    checks++;
    if (res !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mulxuu_result: got %h want fffffffe", res);
    end
    checks++;
    if (id !== 1'b1) begin
      failures++;
      $display("FAIL mulxuu_id: got %b want 1", id);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] res;
    logic id;
    run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, id);
    checks++;
    if (res !== ExpSs || lat !== 7) begin
      failures++;
      $display("FAIL mulxss: got %h lat %0d want %h lat 7", res, lat, ExpSs);
    end
    run_op(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, id);
    checks++;
    if (res !== ExpSu || lat !== 7) begin
      failures++;
      $display("FAIL mulxsu: got %h lat %0d want %h lat 7", res, lat, ExpSu);
    end
    run_op(1'b0, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, lat, res, id);
    checks++;
    if (res !== ExpNeg) begin
      failures++;
      $display("FAIL mulxss_neg2x3: got %h want %h", res, ExpNeg);
    end
  endtask

  task automatic test_stall();
    int w;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b11; req0_src1 = 32'h0001_0000; req0_src2 = 32'h0001_0000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept: got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b00; req1_src1 = 32'd7; req1_src2 = 32'd6;
    w = 0;
    while (!rsp_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 32'd1, 2'b00})
      begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b id=%b r=%h rdy=%b%b want v=1 id=0 r=1 rdy=00",
                 i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_accept_on_rsp: got %b want 0", req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_next_accept: got %b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h0000_002A}) begin
      failures++;
      $display("FAIL stall_followup: got v=%b id=%b r=%h want v=1 id=1 r=0000002a",
               rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b11; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_accept: got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_src1 = 32'd7; req0_src2 = 32'd6;
    #1;
    checks++;
    if ({rsp_valid, req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL abort_idle: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 6 || rsp_result !== 32'h0000_002A || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL abort_followup: got lat=%0d r=%h id=%b want lat=6 r=0000002a id=0",
               lat, rsp_result, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic        gr   [8];
    int          gcyc [8];
    logic        rid  [4];
    logic [31:0] rres [4];
    int ngr, nrsp, cyc, both;
    ngr = 0; nrsp = 0; cyc = 0; both = 0;
    rsp_ready = 1'b1;
    req0_op = 2'b00; req0_src1 = 32'd2; req0_src2 = 32'd3;
    req1_op = 2'b00; req1_src1 = 32'd4; req1_src2 = 32'd5;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (nrsp < 4 && cyc < 200) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if ((req0_ready || req1_ready) && ngr < 8) begin
        gr[ngr] = req1_ready;
        gcyc[ngr] = cyc;
        ngr++;
      end
      if (rsp_valid) begin
        rid[nrsp] = rsp_id;
        rres[nrsp] = rsp_result;
        nrsp++;
      end
      if (nrsp == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (nrsp !== 4 || ngr !== 4) begin
      failures++;
      $display("FAIL b2b_count: got rsp=%0d grants=%0d want 4 4", nrsp, ngr);
    end
    checks++;
    if (both !== 0) begin
      failures++;
      $display("FAIL b2b_one_ready: got %0d dual-ready cycles want 0", both);
    end
    for (int i = 0; i < 4 && i < nrsp && i < ngr; i++) begin
      checks++;
      if (gr[i] !== i[0] || rid[i] !== i[0] || rres[i] !== (i[0] ? 32'd20 : 32'd6)) begin
        failures++;
        $display("FAIL b2b_seq%0d: got grant=%b id=%b r=%h want grant=%b id=%b r=%h",
                 i, gr[i], rid[i], rres[i], i[0], i[0], (i[0] ? 32'd20 : 32'd6));
      end
    end
    if (ngr >= 2) begin
      checks++;
      if (gcyc[1] - gcyc[0] !== 7) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d want 7", gcyc[1] - gcyc[0]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_op = '0;
    req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_op = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_mulxuu();
    test_signed();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
